cordic_vectoring: RTL
=====================

// Module: cordic_vectoring
// PURPOSE
//  Pipelined vectoring-mode CORDIC: the inverse of the rotation-mode cordic block.
//  Takes a Cartesian sample (x,y) in the rotation block's output format (signed Q1.7).
//  Returns phase = atan2(y,x) in the rotation block's input LSB weight (2^-6 rad),
//  plus gain-compensated magnitude. Streaming, one sample per cycle, no backpressure.
//  Sits downstream of the rotation cordic for phase recovery and loopback self-check.
// PARAMETERS
//  W       8   input width; x/y are signed Q1.(W-1)
//  ITER    8   micro-rotation stages (i = 0..ITER-1)
//  GUARD   4   extra LSBs carried internally on x/y datapath
//  ZFRAC   10  internal phase fraction bits; internal phase is signed Q3.ZFRAC
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    asynchronous, active-low reset
//  in_valid   in   1    x_in/y_in valid this cycle
//  x_in       in   W    signed Q1.7 x
//  y_in       in   W    signed Q1.7 y
//  out_valid  out  1    angle/magnitude valid this cycle
//  angle      out  W+1  signed Q3.6 rad, range [-pi,+pi] (+-201 LSB)
//  magnitude  out  W    unsigned Q1.7, sqrt(x^2+y^2)
// BEHAVIOUR
//  Reset (rst=0, async): every pipeline valid bit, out_valid, angle and magnitude clear to 0 immediately.
//    In-flight samples are discarded. No output appears after release until a new in_valid propagates.
//  Latency: fixed ITER+2 cycles from the in_valid edge to out_valid; throughput 1/cycle; order preserved.
//    Samples with in_valid=0 still advance through the pipe but produce out_valid=0.
//  Stage 0 (fold): sign-extend x,y to W+GUARD+2 bits before any negation, so -1.0 (0x80) is safe.
//    x>=0: pass through, z=0.
//    x<0, y>=0: (x,y) <- (y,-x), z=+pi/2.
//    x<0, y<0:  (x,y) <- (-y,x), z=-pi/2.
//  Stage i: d = (y>=0) ? +1 : -1.
//    x' = x + d*(y>>>i); y' = y - d*(x>>>i); z' = z + d*atan(2^-i).
//    Shifts are arithmetic. No saturation inside the pipe; widths make overflow impossible.
//  Output stage:
//    angle = z rounded half-up from ZFRAC to 6 frac bits.
//    magnitude = (x_final * round(2^7/K)) >>> 7, K = 1.64676, rounded, saturated to 2^W-1.
//  x=y=0: angle=0, magnitude=0. A zero flag is carried down the pipe and forces the outputs.
//  Exactly +-pi: (x<0, y=0) yields +201. -pi is produced only for y<0.
//  Accuracy: angle within +-1 LSB and magnitude within +-1 LSB of ideal, for all 2^(2W) inputs.
// STRUCTURE
//  Package cordic_pkg, shared with the rotation cordic:
//    - atan(2^-i) table as a function of (i, ZFRAC)
//    - PI_2 and PI constants at ZFRAC
//    - K_INV_Q7 = 78
//    - Q-format localparams
//  Sub-module cordic_vec_stage (params SHIFT, DW, ZW): one registered micro-rotation.
//    It carries the x, y, z, valid and zero flag. The top generates ITER instances.
//  The top holds the fold register, generate loop and compensation/rounding register.
// TESTING
//  1 x=0x40,y=0x00 -> angle=0, mag=64, out_valid exactly 10 cycles after in_valid (ITER=8).
//  2 x=0x40,y=0x40 -> angle=50+-1, mag=91+-1; x=0x00,y=0x60 -> angle=101+-1, mag=96+-1.
//  3 x=0x80,y=0x00 -> angle=+201, mag=128+-1.
//    x=0xC0,y=0xC0 -> angle=-151+-1, mag=91+-1.
//    x=0x00,y=0x00 -> angle=0, mag=0.
//  4 Loopback: rotation cordic in=0x0E gives (cosine,sine) -> feed as (x,y) -> angle=14+-1.
//    Also in=0x63 -> 99+-1 and in=0xCE -> -50+-1.
//  5 Stream 20 consecutive samples, then 3 idle cycles interleaved.
//    Outputs appear in order, one per cycle, with out_valid gaps matching the input gaps.
//  6 Drop rst low mid-stream, asynchronously between clock edges.
//    Outputs go to 0 before the next edge. After release: no stale out_valid for ITER+2 cycles,
//    then new samples are correct.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the rotation and vectoring CORDIC blocks.
// Angles are fixed-point radians. ATAN and PI reference values are stored at
// high precision and rounded to whatever fraction width a block carries.
package cordic_pkg;

    // Default datapath geometry.
    localparam int CORDIC_W      = 8;
    localparam int CORDIC_ITER   = 8;
    localparam int CORDIC_GUARD  = 4;
    localparam int CORDIC_ZFRAC  = 10;

    // External Q-formats: samples are Q1.(W-1), angles are Q3.6 radians.
    localparam int SAMPLE_FRAC   = CORDIC_W - 1;
    localparam int ANGLE_FRAC    = 6;

    // High-precision references.
    localparam int ATAN_REF_FRAC = 16;
    localparam int PI_REF_FRAC   = 24;
    localparam int PI_REF        = 32'sd52707179;

    // Gain compensation: round(2^7 / 1.64676).
    localparam int K_INV_Q7      = 32'sd78;
    localparam int K_INV_SHIFT   = 7;

    // Arithmetic right shift with round-half-up.
    function automatic int round_shr(input int v, input int sh);
        int r;
        if (sh > 0) begin
            r = (v + (32'sd1 <<< (sh - 1))) >>> sh;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // atan(2^-i) in Q.16 radians.
    function automatic int atan_q16(input int i);
        int t;
        case (i)
            0:       t = 32'sd51472;
            1:       t = 32'sd30386;
            2:       t = 32'sd16055;
            3:       t = 32'sd8150;
            4:       t = 32'sd4091;
            5:       t = 32'sd2047;
            6:       t = 32'sd1024;
            7:       t = 32'sd512;
            8:       t = 32'sd256;
            9:       t = 32'sd128;
            10:      t = 32'sd64;
            11:      t = 32'sd32;
            12:      t = 32'sd16;
            13:      t = 32'sd8;
            14:      t = 32'sd4;
            15:      t = 32'sd2;
            16:      t = 32'sd1;
            default: t = 32'sd0;
        endcase
        return t;
    endfunction

    // atan(2^-i) rounded to 'frac' fraction bits (frac <= 16).
    function automatic int atan_tab(input int i, input int frac);
        return round_shr(atan_q16(i), ATAN_REF_FRAC - frac);
    endfunction

    // pi rounded to 'frac' fraction bits.
    function automatic int pi_at(input int frac);
        return round_shr(PI_REF, PI_REF_FRAC - frac);
    endfunction

    // pi/2 rounded to 'frac' fraction bits.
    function automatic int pi_2_at(input int frac);
        return round_shr(PI_REF, PI_REF_FRAC + 1 - frac);
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered vectoring micro-rotation: drives y toward zero by rotating
// with direction d = sign(y) and accumulates the applied angle into z.
module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int SHIFT = 0,
    parameter int DW    = 14,
    parameter int ZW    = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_s,
    input  logic                 zero_s,
    input  logic signed [DW-1:0] x_s,
    input  logic signed [DW-1:0] y_s,
    input  logic signed [ZW-1:0] z_s,
    output logic                 valid_r,
    output logic                 zero_r,
    output logic signed [DW-1:0] x_r,
    output logic signed [DW-1:0] y_r,
    output logic signed [ZW-1:0] z_r
);
    // Internal phase is Q3.ZFRAC, so the fraction width follows from ZW.
    localparam int ZF = ZW - 3;
    localparam logic signed [ZW-1:0] ATAN_Z = ZW'(atan_tab(SHIFT, ZF));

    logic signed [DW-1:0] x_sh_s;
    logic signed [DW-1:0] y_sh_s;
    logic signed [DW-1:0] x_nx_s;
    logic signed [DW-1:0] y_nx_s;
    logic signed [ZW-1:0] z_nx_s;

    // Micro-rotation toward the x axis; direction taken from the sign of y.
    always_comb begin
        x_sh_s = x_s >>> SHIFT;
        y_sh_s = y_s >>> SHIFT;
        if (!y_s[DW-1]) begin
            x_nx_s = x_s + y_sh_s;
            y_nx_s = y_s - x_sh_s;
            z_nx_s = z_s + ATAN_Z;
        end else begin
            x_nx_s = x_s - y_sh_s;
            y_nx_s = y_s + x_sh_s;
            z_nx_s = z_s - ATAN_Z;
        end
    end

    // Stage register; reset discards whatever sample is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            zero_r  <= 1'b0;
            x_r     <= {DW{1'b0}};
            y_r     <= {DW{1'b0}};
            z_r     <= {ZW{1'b0}};
        end else begin
            valid_r <= valid_s;
            zero_r  <= zero_s;
            x_r     <= x_nx_s;
            y_r     <= y_nx_s;
            z_r     <= z_nx_s;
        end
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Pipelined vectoring-mode CORDIC: (x,y) in Q1.7 -> atan2(y,x) in Q3.6 rad
// plus gain-compensated magnitude in unsigned Q1.7. Latency ITER+2 cycles.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int W     = CORDIC_W,
    parameter int ITER  = CORDIC_ITER,
    parameter int GUARD = CORDIC_GUARD,
    parameter int ZFRAC = CORDIC_ZFRAC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    output logic                out_valid,
    output logic signed [W:0]   angle,
    output logic        [W-1:0] magnitude
);
    // Two extra MSBs absorb the fold negation of -1.0 and the CORDIC gain.
    localparam int DW  = W + GUARD + 2;
    localparam int ZW  = ZFRAC + 3;
    localparam int ZSH = ZFRAC - ANGLE_FRAC;
    localparam int MSH = K_INV_SHIFT + GUARD;
    localparam int MPW = DW + 6;

    localparam logic signed [ZW-1:0] PI_2_Z = ZW'(pi_2_at(ZFRAC));
    localparam logic signed [ZW-1:0] Z_HALF = ZW'(32'sd1 <<< (ZSH - 1));
    localparam logic signed [ZW-1:0] PI_ANG = ZW'(pi_at(ANGLE_FRAC));
    localparam logic [MPW-1:0] K_INV  = MPW'(K_INV_Q7);
    localparam logic [MPW-1:0] M_HALF = MPW'(32'sd1 <<< (MSH - 1));
    localparam logic [MPW-1:0] M_MAX  = MPW'((32'sd1 <<< W) - 32'sd1);

    logic signed [DW-1:0] x_ext_s;
    logic signed [DW-1:0] y_ext_s;
    logic signed [DW-1:0] fx_s;
    logic signed [DW-1:0] fy_s;
    logic signed [ZW-1:0] fz_s;
    logic                 fzero_s;

    logic                 v0_r;
    logic                 zero0_r;
    logic signed [DW-1:0] x0_r;
    logic signed [DW-1:0] y0_r;
    logic signed [ZW-1:0] z0_r;

    logic                 v_chain_s    [0:ITER];
    logic                 zero_chain_s [0:ITER];
    logic signed [DW-1:0] x_chain_s    [0:ITER];
    logic signed [DW-1:0] y_chain_s    [0:ITER];
    logic signed [ZW-1:0] z_chain_s    [0:ITER];

    logic signed [DW-1:0] x_last_s;
    logic signed [ZW-1:0] z_sum_s;
    logic signed [ZW-1:0] z_rnd_s;
    logic signed [ZW-1:0] ang_sat_s;
    logic        [DW-2:0] x_mag_s;
    logic       [MPW-1:0] mag_prod_s;
    logic       [MPW-1:0] mag_rnd_s;
    logic        [W-1:0]  mag_sat_s;
    logic signed [W:0]    angle_nx_s;
    logic        [W-1:0]  mag_nx_s;
    logic                 y_last_unused_s;

    logic                 out_valid_r;
    logic signed [W:0]    angle_r;
    logic        [W-1:0]  magnitude_r;

    // Fold left-half-plane samples into the right half plane, seeding z with +-pi/2.
    always_comb begin
        x_ext_s = {{2{x_in[W-1]}}, x_in, {GUARD{1'b0}}};
        y_ext_s = {{2{y_in[W-1]}}, y_in, {GUARD{1'b0}}};
        fzero_s = (x_in == {W{1'b0}}) && (y_in == {W{1'b0}});
        if (!x_in[W-1]) begin
            fx_s = x_ext_s;
            fy_s = y_ext_s;
            fz_s = {ZW{1'b0}};
        end else if (!y_in[W-1]) begin
            // y = 0 lands here, so x<0,y=0 resolves to +pi.
            fx_s = y_ext_s;
            fy_s = -x_ext_s;
            fz_s = PI_2_Z;
        end else begin
            fx_s = -y_ext_s;
            fy_s = x_ext_s;
            fz_s = -PI_2_Z;
        end
    end

    // Fold register: first pipeline stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0_r    <= 1'b0;
            zero0_r <= 1'b0;
            x0_r    <= {DW{1'b0}};
            y0_r    <= {DW{1'b0}};
            z0_r    <= {ZW{1'b0}};
        end else begin
            v0_r    <= in_valid;
            zero0_r <= fzero_s;
            x0_r    <= fx_s;
            y0_r    <= fy_s;
            z0_r    <= fz_s;
        end
    end

    assign v_chain_s[0]    = v0_r;
    assign zero_chain_s[0] = zero0_r;
    assign x_chain_s[0]    = x0_r;
    assign y_chain_s[0]    = y0_r;
    assign z_chain_s[0]    = z0_r;

    for (genvar gi = 0; gi < ITER; gi++) begin : g_stage
        cordic_vec_stage #(
            .SHIFT (gi),
            .DW    (DW),
            .ZW    (ZW)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .valid_s (v_chain_s[gi]),
            .zero_s  (zero_chain_s[gi]),
            .x_s     (x_chain_s[gi]),
            .y_s     (y_chain_s[gi]),
            .z_s     (z_chain_s[gi]),
            .valid_r (v_chain_s[gi+1]),
            .zero_r  (zero_chain_s[gi+1]),
            .x_r     (x_chain_s[gi+1]),
            .y_r     (y_chain_s[gi+1]),
            .z_r     (z_chain_s[gi+1])
        );
    end

    // The final residual y is not needed for the result.
    assign y_last_unused_s = ^y_chain_s[ITER];

    // Round phase to Q3.6 and clamp to +-pi; compensate gain on the magnitude.
    always_comb begin
        x_last_s = x_chain_s[ITER];
        z_sum_s  = z_chain_s[ITER] + Z_HALF;
        z_rnd_s  = z_sum_s >>> ZSH;
        if (z_rnd_s > PI_ANG) begin
            ang_sat_s = PI_ANG;
        end else if (z_rnd_s < -PI_ANG) begin
            ang_sat_s = -PI_ANG;
        end else begin
            ang_sat_s = z_rnd_s;
        end

        // x only grows after the fold, but never let a negative value wrap.
        if (x_last_s[DW-1]) begin
            x_mag_s = {(DW-1){1'b0}};
        end else begin
            x_mag_s = x_last_s[DW-2:0];
        end
        mag_prod_s = {7'b0000000, x_mag_s} * K_INV;
        mag_rnd_s  = (mag_prod_s + M_HALF) >> MSH;
        if (mag_rnd_s > M_MAX) begin
            mag_sat_s = {W{1'b1}};
        end else begin
            mag_sat_s = mag_rnd_s[W-1:0];
        end

        // The origin has no defined phase; force both outputs to zero.
        if (zero_chain_s[ITER]) begin
            angle_nx_s = {(W+1){1'b0}};
            mag_nx_s   = {W{1'b0}};
        end else begin
            angle_nx_s = ang_sat_s[W:0];
            mag_nx_s   = mag_sat_s;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            angle_r     <= {(W+1){1'b0}};
            magnitude_r <= {W{1'b0}};
        end else begin
            out_valid_r <= v_chain_s[ITER];
            angle_r     <= angle_nx_s;
            magnitude_r <= mag_nx_s;
        end
    end

    assign out_valid = out_valid_r;
    assign angle     = angle_r;
    assign magnitude = magnitude_r;

endmodule
